// File: rtl/uart_disp_pkg.sv
// rtl/uart_disp_pkg.sv - shared codes, FSM states and window entry type for the UART display buffer
package uart_disp_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;

    typedef enum logic {
        IDLE,
        HEX_LO
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       is_ascii;
        logic [7:0] ch;
    } disp_entry_t;

    localparam disp_entry_t EMPTY_ENTRY = '0;

endpackage

// File: rtl/uart_char_display_buffer_if.sv
// rtl/uart_char_display_buffer_if.sv - received-byte handshake between UART RX and the display buffer
interface uart_char_display_buffer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/display_scan_counter.sv
// rtl/display_scan_counter.sv - prescaler and digit index for time-multiplexed display scanning
module display_scan_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    localparam int IDX_W     = $clog2(NUM_DIGITS),
    localparam int PRE_W     = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] index,
    output logic             tick
);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        tick  = (pre_q == PRE_W'(SCAN_DIV - 1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    assign index = idx_q;

endmodule

// File: rtl/uart_char_display_buffer.sv
// rtl/uart_char_display_buffer.sv - scrolling character window fed by UART RX, scanned onto one decoder
module uart_char_display_buffer
    import uart_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_char_display_buffer_if.slave     rx,
    input  logic                          mode_hex,
    input  logic                          clear,
    output logic [7:0]                    char_out,
    output logic                          asci_or_hexa,
    output logic [NUM_DIGITS-1:0]         digit_en_n
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    state_t               state_q, state_d;
    logic [3:0]           lo_q, lo_d;
    disp_entry_t          win_q [NUM_DIGITS];
    disp_entry_t          win_d [NUM_DIGITS];
    logic [7:0]           char_q, char_d;
    logic                 asc_q, asc_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;

    logic [IDX_W-1:0]     scan_idx;
    logic                 scan_tick_unused;
    logic                 rdy;
    logic                 accept;
    logic                 push, pop, wipe;
    disp_entry_t          push_e;
    disp_entry_t          lit;

    display_scan_counter #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .index (scan_idx),
        .tick  (scan_tick_unused)
    );

    assign rdy         = (state_q == IDLE);
    assign accept      = rx.rx_valid & rdy;
    assign rx.rx_ready = rdy;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        win_d   = win_q;
        push    = 1'b0;
        pop     = 1'b0;
        wipe    = 1'b0;
        push_e  = EMPTY_ENTRY;

        // clear beats everything, including a pending low nibble
        if (clear) begin
            wipe    = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (mode_hex) begin
                            push    = 1'b1;
                            push_e  = '{valid: 1'b1, is_ascii: 1'b0, ch: {4'h0, rx.rx_data[7:4]}};
                            lo_d    = rx.rx_data[3:0];
                            state_d = HEX_LO;
                        end else if (rx.rx_data == ASCII_CR) begin
                            wipe = 1'b1;
                        end else if (rx.rx_data == ASCII_BS) begin
                            pop = 1'b1;
                        end else begin
                            push   = 1'b1;
                            push_e = '{valid: 1'b1, is_ascii: 1'b1, ch: rx.rx_data};
                        end
                    end
                end
                HEX_LO: begin
                    push    = 1'b1;
                    push_e  = '{valid: 1'b1, is_ascii: 1'b0, ch: {4'h0, lo_q}};
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (wipe) begin
            for (int i = 0; i < NUM_DIGITS; i++) win_d[i] = EMPTY_ENTRY;
        end else if (push) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) win_d[i] = win_q[i-1];
            win_d[0] = push_e;
        end else if (pop) begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) win_d[i] = win_q[i+1];
            win_d[NUM_DIGITS-1] = EMPTY_ENTRY;
        end
    end

    // blank digits keep the last character so the decoder input stays quiet
    always_comb begin
        lit    = win_q[scan_idx];
        char_d = lit.valid ? lit.ch : char_q;
        asc_d  = lit.valid ? lit.is_ascii : asc_q;
        en_d   = lit.valid ? ~(NUM_DIGITS'(1) << scan_idx) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q    <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) win_q[i] <= EMPTY_ENTRY;
            char_q  <= 8'h00;
            asc_q   <= 1'b1;
            en_q    <= '1;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            win_q   <= win_d;
            char_q  <= char_d;
            asc_q   <= asc_d;
            en_q    <= en_d;
        end
    end

    assign char_out     = char_q;
    assign asci_or_hexa = asc_q;
    assign digit_en_n   = en_q;

endmodule

// File: tb/tb_uart_char_display_buffer.sv
// tb/tb_uart_char_display_buffer.sv - bench for uart_char_display_buffer with queue-based reference model
module tb_uart_char_display_buffer;

    localparam int N  = 4;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode_hex = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] char_out;
    logic       asci_or_hexa;
    logic [N-1:0] digit_en_n;

    uart_char_display_buffer_if rx_if ();

    uart_char_display_buffer #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx_if.slave),
        .mode_hex     (mode_hex),
        .clear        (clear),
        .char_out     (char_out),
        .asci_or_hexa (asci_or_hexa),
        .digit_en_n   (digit_en_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         asc;
        logic [7:0] ch;
    } ent_t;

    ent_t       mq[$];
    bit         pending = 1'b0;
    logic [3:0] lo_nib = 4'h0;
    int         cyc = 0;
    logic [7:0] exp_char = 8'h00;
    logic       exp_asc = 1'b1;
    logic [N-1:0] exp_en = '1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input bit a, input logic [7:0] c);
        ent_t e;
        e.asc = a;
        e.ch  = c;
        mq.push_front(e);
        if (mq.size() > N) void'(mq.pop_back());
    endtask

    // reference: window as a queue (newest first), scan position from edge count
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                pending  = 1'b0;
                cyc      = 0;
                exp_char = 8'h00;
                exp_asc  = 1'b1;
                exp_en   = '1;
            end else begin
                int idx;
                idx = (cyc / SD) % N;
                if (idx < mq.size()) begin
                    exp_char = mq[idx].ch;
                    exp_asc  = mq[idx].asc;
                    exp_en   = ~(N'(1) << idx);
                end else begin
                    exp_en = '1;
                end
                cyc++;
                if (clear) begin
                    mq.delete();
                    pending = 1'b0;
                end else if (pending) begin
                    model_push(1'b0, {4'h0, lo_nib});
                    pending = 1'b0;
                end else if (rx_if.rx_valid) begin
                    if (mode_hex) begin
                        model_push(1'b0, {4'h0, rx_if.rx_data[7:4]});
                        lo_nib  = rx_if.rx_data[3:0];
                        pending = 1'b1;
                    end else if (rx_if.rx_data == 8'h0D) begin
                        mq.delete();
                    end else if (rx_if.rx_data == 8'h08) begin
                        if (mq.size() > 0) void'(mq.pop_front());
                    end else begin
                        model_push(1'b1, rx_if.rx_data);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("char_out", char_out, exp_char);
            check("asci_or_hexa", asci_or_hexa, exp_asc);
            check("digit_en_n", digit_en_n, exp_en);
            check("rx_ready", rx_if.rx_ready, !pending);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic hex);
        int tries;
        tries = 0;
        @(posedge clk);
        #1;
        while (!rx_if.rx_ready && tries < 4) begin
            @(posedge clk);
            #1;
            tries++;
        end
        if (tries == 4) check("send ready timeout", 0, 1);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = d;
        mode_hex       = hex;
        @(posedge clk);
        #1;
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // one full scan period: each stored digit must be lit exactly SD cycles with its own content
    task automatic scan_check(input string name, input logic [31:0] chs, input logic [3:0] vld,
                              input logic [3:0] asc);
        int seen [N];
        int blank;
        int n_empty;
        logic [N-1:0] pat;
        blank   = 0;
        n_empty = 0;
        for (int d = 0; d < N; d++) seen[d] = 0;
        repeat (N * SD) begin
            @(negedge clk);
            if (digit_en_n == '1) blank++;
            for (int d = 0; d < N; d++) begin
                pat = ~(N'(1) << d);
                if (digit_en_n == pat) begin
                    seen[d]++;
                    check({name, " char"}, char_out, chs[8*d +: 8]);
                    check({name, " ascii"}, asci_or_hexa, asc[d]);
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            check({name, " lit cycles"}, seen[d], vld[d] ? SD : 0);
            if (!vld[d]) n_empty++;
        end
        check({name, " blank cycles"}, blank, n_empty * SD);
    endtask

    initial begin
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset digit_en_n", digit_en_n, 4'b1111);
            check("reset rx_ready", rx_if.rx_ready, 1'b1);
            check("reset ascii", asci_or_hexa, 1'b1);
            check("reset char", char_out, 8'h00);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        send("A", 1'b0); send("b", 1'b0); send("1", 1'b0); send("2", 1'b0); send("3", 1'b0);
        idle(2);
        scan_check("ascii scroll", {"b", "1", "2", "3"}, 4'b1111, 4'b1111);

        do_clear();
        send(8'hA5, 1'b1);
        check("hex lo stall", rx_if.rx_ready, 1'b0);
        @(posedge clk);
        #1;
        check("hex ready back", rx_if.rx_ready, 1'b1);
        idle(2);
        scan_check("hex A5", {8'h00, 8'h00, 8'h0A, 8'h05}, 4'b0011, 4'b0000);

        do_clear();
        send("H", 1'b0); send("I", 1'b0); send(8'h08, 1'b0);
        idle(2);
        scan_check("backspace", {8'h00, 8'h00, 8'h00, "H"}, 4'b0001, 4'b0001);
        send(8'h08, 1'b0); send(8'h08, 1'b0);
        idle(2);
        scan_check("bs on empty", 32'h0, 4'b0000, 4'b0000);
        send("H", 1'b0); send("I", 1'b0); send("L", 1'b0);
        idle(2);
        scan_check("HIL", {8'h00, "H", "I", "L"}, 4'b0111, 4'b0111);
        send(8'h0D, 1'b0);
        idle(2);
        scan_check("carriage return", 32'h0, 4'b0000, 4'b0000);

        send(8'h3C, 1'b1);
        clear = 1'b1;
        check("clear in hex_lo stall", rx_if.rx_ready, 1'b0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear in hex_lo ready", rx_if.rx_ready, 1'b1);
        idle(2);
        scan_check("clear abort", 32'h0, 4'b0000, 4'b0000);

        send("w", 1'b0); send("x", 1'b0); send("y", 1'b0); send("z", 1'b0);
        idle(7);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst digit_en_n", digit_en_n, 4'b1111);
        check("async rst char", char_out, 8'h00);
        check("async rst ascii", asci_or_hexa, 1'b1);
        check("async rst ready", rx_if.rx_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send("Z", 1'b0);
        idle(2);
        scan_check("after reset", {8'h00, 8'h00, 8'h00, "Z"}, 4'b0001, 4'b0001);

        repeat (3000) begin
            int r;
            @(posedge clk);
            #1;
            r = $urandom_range(0, 7);
            rx_if.rx_valid = ($urandom_range(0, 2) != 0);
            rx_if.rx_data  = (r == 0) ? 8'h08 : (r == 1) ? 8'h0D : 8'($urandom);
            mode_hex       = ($urandom_range(0, 2) == 0);
            clear          = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk);
        #1;
        rx_if.rx_valid = 1'b0;
        clear          = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
